bm_if_collapse_multi: RTL

- Parametrised successor to the nested-if and case collapse micro benchmark.
- Contains CHANNELS independent conditional-update register lanes, each WIDTH bits, with a run-time selectable logic op.
- Contains a decode/hold register pair on lane 0 that feeds out2.
- Contains a small FSM that freezes out2 after HOLD_MAX consecutive update cycles on lane 0; it gives the synthesis flow a mix of if-collapse, case-decode and FSM structure.

---
 rtl/bm_if_collapse_multi.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bm_if_collapse_multi.sv
// bm_if_collapse_multi: CHANNELS conditional-update lanes, a lane-0 decode/hold
// pair feeding out2, and an FSM that freezes out2 after HOLD_MAX lane-0 hits.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   a_in, b_in     per-lane operands, lane i at [i*WIDTH +: WIDTH]
//   c_in           per-lane enable (0 clears the lane)
//   d_in           per-lane load strobe
//   mode_in        00 AND, 01 OR, 10 XOR, 11 HOLD
//   out0, out1     lane results and "loaded" flags
//   out2           lane-0 decode result, frozen while busy
//   busy           FSM is in FREEZE
module bm_if_collapse_multi #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int HOLD_MAX = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] a_in,
  input  logic [CHANNELS*WIDTH-1:0] b_in,
  input  logic [CHANNELS-1:0]       c_in,
  input  logic [CHANNELS-1:0]       d_in,
  input  logic [1:0]                mode_in,
  output logic [CHANNELS*WIDTH-1:0] out0,
  output logic [CHANNELS-1:0]       out1,
  output logic [WIDTH-1:0]          out2,
  output logic                      busy
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COUNT  = 2'b01,
    FREEZE = 2'b10
  } state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [WIDTH-1:0]          t1;
  logic [WIDTH-1:0]          t2;
  logic [CHANNELS*WIDTH-1:0] op_res;

  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             hit;

  assign a0   = a_in[WIDTH-1:0];
  assign b0   = b_in[WIDTH-1:0];
  assign hit  = c_in[0] & d_in[0];
  assign busy = (state == FREEZE);

  // Mode 11 feeds the lane back so a load strobe only sets the flag.
  always_comb begin
    op_res = out0;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (mode_in)
        2'b00: op_res[i*WIDTH +: WIDTH] =
                 a_in[i*WIDTH +: WIDTH] & b_in[i*WIDTH +: WIDTH];
        2'b01: op_res[i*WIDTH +: WIDTH] =
                 a_in[i*WIDTH +: WIDTH] | b_in[i*WIDTH +: WIDTH];
        2'b10: op_res[i*WIDTH +: WIDTH] =
                 a_in[i*WIDTH +: WIDTH] ^ b_in[i*WIDTH +: WIDTH];
        2'b11: op_res[i*WIDTH +: WIDTH] = out0[i*WIDTH +: WIDTH];
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out0 <= '0;
      out1 <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!c_in[i]) begin
          out0[i*WIDTH +: WIDTH] <= '0;
          out1[i]                <= 1'b0;
        end else if (d_in[i]) begin
          out0[i*WIDTH +: WIDTH] <= op_res[i*WIDTH +: WIDTH];
          out1[i]                <= 1'b1;
        end
      end
    end
  end

  // t1/t2 keep updating during FREEZE; only out2 is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      t1   <= '0;
      t2   <= '0;
      out2 <= '0;
    end else begin
      if (a0 != '0)
        t1 <= ~a0;
      else if (b0 != WIDTH'(1))
        t2 <= '1;
      if (state != FREEZE)
        out2 <= t1 & t2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit && HOLD_MAX == 1) begin
            state <= FREEZE;
            cnt   <= '0;
          end else if (hit) begin
            state <= COUNT;
            cnt   <= CW'(1);
          end else begin
            cnt   <= '0;
          end
        end
        COUNT: begin
          if (hit && (cnt + CW'(1)) == CW'(HOLD_MAX)) begin
            state <= FREEZE;
            cnt   <= '0;
          end else if (hit) begin
            cnt   <= cnt + CW'(1);
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        FREEZE: begin
          cnt <= '0;
          if (!c_in[0])
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
